// File: rtl/ldm_stm_sequencer.sv
// Purpose : expands an LDM/STM register list into single-register micro-ops plus an optional base-writeback micro-op.
// Latency : first micro-op is presented the cycle after start is sampled in IDLE; one micro-op per cycle while uop_ready is high.
// Backpressure: uop_ready low holds every uop_* output stable; outputs depend only on registered state, never on uop_ready.
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   start           Decode holds a block transfer (sampled only in IDLE)
//   RegList         register list, one bit per architectural register
//   PBit/UBit/WBit  pre-index / increment / base-writeback
//   SBit            user-bank request (only meaningful with LDMSTM_USERBANK_EN)
//   uop_ready       pipeline accepts the presented micro-op
//   uop_valid       micro-op presented
//   uop_reg         transfer register index (0 for writeback)
//   uop_offset      signed byte offset from Rn, replaces ExtImm
//   uop_wb          writeback micro-op (Rn <= Rn + uop_offset)
//   uop_last        final micro-op of the sequence
//   uop_user        transfer uses the user register bank
//   busy            sequence in progress, stalls Fetch/Decode
//
// Build option: define LDMSTM_USERBANK_EN to honour SBit (user-bank transfers, writeback suppressed).

module ldm_stm_sequencer #(
  parameter int NREG = 16,
  parameter int STEP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NREG-1:0]         RegList,
  input  logic                    PBit,
  input  logic                    UBit,
  input  logic                    WBit,
  input  logic                    SBit,
  input  logic                    uop_ready,
  output logic                    uop_valid,
  output logic [$clog2(NREG)-1:0] uop_reg,
  output logic [31:0]             uop_offset,
  output logic                    uop_wb,
  output logic                    uop_last,
  output logic                    uop_user,
  output logic                    busy
);

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  // S_EMPTY is the single busy cycle for an empty list without writeback.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_WB    = 2'd2,
    S_EMPTY = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [NREG-1:0] r_mask;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_offset;
  logic            r_up;
  logic            r_wb_en;
  logic            r_user;

  logic [CW-1:0]   w_pop;
  logic [31:0]     w_span;
  logic [31:0]     w_start_off;
  logic [NREG-1:0] w_low;
  logic [RW-1:0]   w_low_idx;
  logic            w_single;
  logic [31:0]     w_wb_mag;
  logic [31:0]     w_wb_off;
  logic            w_user_req;
  logic            w_wb_req;

  // User-bank transfers never write back the base; a list containing the PC
  // is a PSR restore and stays on the current bank.
`ifdef LDMSTM_USERBANK_EN
  assign w_user_req = SBit & ~RegList[NREG-1];
  assign w_wb_req   = WBit & ~w_user_req;
`else
  logic w_unused_sbit;
  assign w_unused_sbit = SBit;
  assign w_user_req    = 1'b0;
  assign w_wb_req      = WBit;
`endif

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NREG; i++) begin
      w_pop = w_pop + CW'(RegList[i]);
    end
  end

  assign w_span = 32'(STEP * int'(w_pop));

  // Offset of the first (lowest-numbered) register; later registers always
  // step upward, so descending modes start below Rn.
  always_comb begin
    w_start_off = '0;
    case ({PBit, UBit})
      2'b01:   w_start_off = '0;
      2'b11:   w_start_off = 32'(STEP);
      2'b00:   w_start_off = 32'(STEP) - w_span;
      default: w_start_off = 32'(0) - w_span;
    endcase
  end

  // Isolate the lowest set bit of the remaining mask.
  assign w_low    = r_mask & (~r_mask + NREG'(1));
  assign w_single = ((r_mask & ~w_low) == '0);

  always_comb begin
    w_low_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_low_idx = RW'(i);
      end
    end
  end

  // An empty list still moves the base by a full register-file span.
  assign w_wb_mag = 32'(STEP * ((r_count == '0) ? NREG : int'(r_count)));
  assign w_wb_off = r_up ? w_wb_mag : (32'(0) - w_wb_mag);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mask   <= '0;
      r_count  <= '0;
      r_offset <= '0;
      r_up     <= 1'b0;
      r_wb_en  <= 1'b0;
      r_user   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask   <= RegList;
            r_count  <= w_pop;
            r_offset <= w_start_off;
            r_up     <= UBit;
            r_wb_en  <= w_wb_req;
            r_user   <= w_user_req;
          end
        end
        S_XFER: begin
          if (uop_ready) begin
            r_mask   <= r_mask & ~w_low;
            r_offset <= r_offset + 32'(STEP);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    uop_valid  = 1'b0;
    uop_reg    = '0;
    uop_offset = '0;
    uop_wb     = 1'b0;
    uop_last   = 1'b0;
    uop_user   = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_pop != '0) begin
            w_next = S_XFER;
          end else if (w_wb_req) begin
            w_next = S_WB;
          end else begin
            w_next = S_EMPTY;
          end
        end
      end
      S_XFER: begin
        uop_valid  = 1'b1;
        uop_reg    = w_low_idx;
        uop_offset = r_offset;
        uop_user   = r_user;
        uop_last   = w_single & ~r_wb_en;
        busy       = 1'b1;
        if (uop_ready && w_single) begin
          w_next = r_wb_en ? S_WB : S_IDLE;
        end
      end
      S_WB: begin
        uop_valid  = 1'b1;
        uop_wb     = 1'b1;
        uop_last   = 1'b1;
        uop_offset = w_wb_off;
        busy       = 1'b1;
        if (uop_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        busy   = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] RegList;
  logic        PBit, UBit, WBit, SBit;
  logic        uop_ready;
  logic        uop_valid;
  logic [3:0]  uop_reg;
  logic [31:0] uop_offset;
  logic        uop_wb, uop_last, uop_user, busy;

  int n_tests = 0;
  int n_fail  = 0;

  ldm_stm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .RegList    (RegList),
    .PBit       (PBit),
    .UBit       (UBit),
    .WBit       (WBit),
    .SBit       (SBit),
    .uop_ready  (uop_ready),
    .uop_valid  (uop_valid),
    .uop_reg    (uop_reg),
    .uop_offset (uop_offset),
    .uop_wb     (uop_wb),
    .uop_last   (uop_last),
    .uop_user   (uop_user),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Packed view: {valid, reg[3:0], offset[31:0], wb, last, user, busy}
  function automatic logic [40:0] uo(input int v, input int r, input logic [31:0] off,
                                     input int wb, input int last, input int user, input int b);
    logic [3:0] r4;
    r4 = r[3:0];
    return {v[0], r4, off, wb[0], last[0], user[0], b[0]};
  endfunction

  localparam logic [40:0] IDLE = 41'd0;

  task automatic chk(input string tag, input logic [40:0] exp);
    logic [40:0] obs;
    obs = {uop_valid, uop_reg, uop_offset, uop_wb, uop_last, uop_user, busy};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents start for one rising edge and returns
  // at the falling edge where the first micro-op (if any) is visible.
  task automatic launch(input logic [15:0] l, input int p, input int u, input int w, input int s);
    start   = 1'b1;
    RegList = l;
    PBit    = p[0];
    UBit    = u[0];
    WBit    = w[0];
    SBit    = s[0];
    @(negedge clk);
    start   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; RegList = '0;
    PBit = 1'b0; UBit = 1'b0; WBit = 1'b0; SBit = 1'b0;
    uop_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_idle", IDLE);
    start = 1'b1; RegList = 16'h00FF;
    @(negedge clk);
    chk("start_in_reset", IDLE);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", IDLE);

    // LDMIA {r1-r3}! ; a start pulse mid-sequence must be ignored
    launch(16'h000E, 0, 1, 1, 0);
    chk("t1_r1", uo(1, 1, 32'h0, 0, 0, 0, 1));
    start = 1'b1; RegList = 16'h0F00;
    @(negedge clk); start = 1'b0;
    chk("t1_r2", uo(1, 2, 32'h4, 0, 0, 0, 1));
    @(negedge clk);
    chk("t1_r3", uo(1, 3, 32'h8, 0, 0, 0, 1));
    @(negedge clk);
    chk("t1_wb", uo(1, 0, 32'hC, 1, 1, 0, 1));
    @(negedge clk);
    chk("t1_idle", IDLE);

    // STMDB {r4,r14}!
    launch(16'h4010, 1, 0, 1, 0);
    chk("t2_r4", uo(1, 4, 32'hFFFFFFF8, 0, 0, 0, 1));
    @(negedge clk);
    chk("t2_r14", uo(1, 14, 32'hFFFFFFFC, 0, 0, 0, 1));
    @(negedge clk);
    chk("t2_wb", uo(1, 0, 32'hFFFFFFF8, 1, 1, 0, 1));
    @(negedge clk);
    chk("t2_idle", IDLE);

    // LDMIB {r0} with three stalled cycles
    uop_ready = 1'b0;
    launch(16'h0001, 1, 1, 0, 0);
    chk("t3_stall0", uo(1, 0, 32'h4, 0, 1, 0, 1));
    @(negedge clk);
    chk("t3_stall1", uo(1, 0, 32'h4, 0, 1, 0, 1));
    @(negedge clk);
    chk("t3_stall2", uo(1, 0, 32'h4, 0, 1, 0, 1));
    uop_ready = 1'b1;
    @(negedge clk);
    chk("t3_idle", IDLE);

    // Empty lists
    launch(16'h0000, 0, 1, 1, 0);
    chk("t4_wb_up", uo(1, 0, 32'h40, 1, 1, 0, 1));
    @(negedge clk);
    chk("t4_idle_a", IDLE);
    launch(16'h0000, 0, 1, 0, 0);
    chk("t4_busy_only", uo(0, 0, 32'h0, 0, 0, 0, 1));
    @(negedge clk);
    chk("t4_idle_b", IDLE);
    launch(16'h0000, 1, 0, 1, 0);
    chk("t4_wb_down", uo(1, 0, 32'hFFFFFFC0, 1, 1, 0, 1));
    @(negedge clk);
    chk("t4_idle_c", IDLE);

    // LDMDA {r0-r7}! aborted by reset on the second micro-op
    launch(16'h00FF, 0, 0, 1, 0);
    chk("t5_r0", uo(1, 0, 32'hFFFFFFE4, 0, 0, 0, 1));
    @(negedge clk);
    chk("t5_r1", uo(1, 1, 32'hFFFFFFE8, 0, 0, 0, 1));
    reset = 1'b0;
    @(negedge clk);
    chk("t5_abort", IDLE);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_no_wb", IDLE);
    launch(16'h0003, 0, 1, 0, 0);
    chk("t5_new_r0", uo(1, 0, 32'h0, 0, 0, 0, 1));
    @(negedge clk);
    chk("t5_new_r1", uo(1, 1, 32'h4, 0, 1, 0, 1));
    @(negedge clk);
    chk("t5_new_idle", IDLE);

    // SBit with {r0,r1}!
`ifdef LDMSTM_USERBANK_EN
    launch(16'h0003, 0, 1, 1, 1);
    chk("t6_r0_user", uo(1, 0, 32'h0, 0, 0, 1, 1));
    @(negedge clk);
    chk("t6_r1_user", uo(1, 1, 32'h4, 0, 1, 1, 1));
    @(negedge clk);
    chk("t6_idle", IDLE);
`else
    launch(16'h0003, 0, 1, 1, 1);
    chk("t6_r0", uo(1, 0, 32'h0, 0, 0, 0, 1));
    @(negedge clk);
    chk("t6_r1", uo(1, 1, 32'h4, 0, 0, 0, 1));
    @(negedge clk);
    chk("t6_wb", uo(1, 0, 32'h8, 1, 1, 0, 1));
    @(negedge clk);
    chk("t6_idle", IDLE);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
